// File: rtl/mux8_scan_seq.sv
// Scan sequencer for a CM151 8:1 mux: steps the select lines through all eight
// channels, captures each mux output into an 8-bit word, and checks that n_in is the complement of m_in.
module mux8_scan_seq #(
    parameter int unsigned SETTLE = 1
) (
    input  logic       clk_pad,
    input  logic       rstn_pad,
    input  logic       start,
    input  logic       abort,
    input  logic       m_in,
    input  logic       n_in,
    output logic       sel_i,
    output logic       sel_j,
    output logic       sel_k,
    output logic       dis_l,
    output logic       busy,
    output logic [7:0] out_word,
    output logic       out_err,
    output logic       out_valid,
    input  logic       out_ready
);

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

    state_t     state, state_nxt;
    logic [2:0] idx;
    logic [3:0] cnt;
    logic       accept;
    logic       capture;

    always_ff @(posedge clk_pad or negedge rstn_pad) begin
        if (!rstn_pad) state <= IDLE;
        else           state <= state_nxt;
    end

    // abort takes priority over both the settle exit and the SAMPLE capture
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = DRIVE;
                end
            end
            DRIVE: begin
                if (abort)            state_nxt = IDLE;
                else if (cnt == 4'd1) state_nxt = SAMPLE;
            end
            SAMPLE: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else begin
                    capture   = 1'b1;
                    state_nxt = (idx == 3'd7) ? DONE : DRIVE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    if (start) begin
                        accept    = 1'b1;
                        state_nxt = DRIVE;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_pad or negedge rstn_pad) begin
        if (!rstn_pad) begin
            idx      <= '0;
            cnt      <= '0;
            out_word <= '0;
            out_err  <= 1'b0;
        end else if (accept) begin
            idx      <= '0;
            cnt      <= 4'(SETTLE);
            out_word <= '0;
            out_err  <= 1'b0;
        end else if (capture) begin
            out_word[idx] <= m_in;
            if (n_in == m_in) out_err <= 1'b1;
            if (idx != 3'd7) begin
                idx <= idx + 3'd1;
                cnt <= 4'(SETTLE);
            end
        end else if (state == DRIVE && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

    always_comb begin
        busy      = (state == DRIVE) || (state == SAMPLE);
        dis_l     = !busy;
        out_valid = (state == DONE);
        {sel_k, sel_j, sel_i} = busy ? idx : 3'd0;
    end

endmodule

// File: doc/mux8_scan_seq.md
MUX8_SCAN_SEQ -- requirements
Module: mux8_scan_seq

Interface
REQ-001 SHALL provide parameter SETTLE, default 1, range 1..15: cycles select lines are held before each sample.
REQ-002 SHALL provide port clk_pad  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL provide port rstn_pad  input  1  reset, asynchronous, active-low.
REQ-004 SHALL provide port start  input  1  scan request.
REQ-005 SHALL provide port abort  input  1  cancel an in-progress scan.
REQ-006 SHALL provide port m_in  input  1  mux data output from the CM151 stage (m_pad).
REQ-007 SHALL provide port n_in  input  1  complementary mux output from the CM151 stage (n_pad).
REQ-008 SHALL provide port sel_i, sel_j, sel_k  output  1 each  channel-select bits to i_pad, j_pad and k_pad; the channel index is {k,j,i}, with channel 0 = a_pad and channel 7 = h_pad.
REQ-009 SHALL provide port dis_l  output  1  mux disable to l_pad; 1 forces m=0.
REQ-010 SHALL provide port busy  output  1  scan in progress.
REQ-011 SHALL provide port out_word  output  8  captured word; bit n = the value of channel n.
REQ-012 SHALL provide port out_err  output  1  complement-check failure seen during the scan.
REQ-013 SHALL provide port out_valid / out_ready  output / input  1 each  result handshake.

Function
REQ-014 SHALL implement the states IDLE, DRIVE, SAMPLE and DONE.
REQ-015 IDLE: if start=1, SHALL on the next edge clear idx, settle count, out_word and the err accumulator, and go to DRIVE.
REQ-016 DRIVE: SHALL drive {sel_k,sel_j,sel_i}=idx and dis_l=0, hold for SETTLE cycles, then go to SAMPLE.
REQ-017 SAMPLE: SHALL capture m_in into out_word[idx] on the edge that leaves SAMPLE.
REQ-018 SAMPLE: on that same edge, SHALL set the err accumulator if n_in != ~m_in.
REQ-019 SAMPLE: if idx<7, SHALL increment idx and return to DRIVE; if idx=7, SHALL go to DONE.
REQ-020 The select lines SHALL stay stable from the first DRIVE cycle of a channel through its SAMPLE cycle.
REQ-021 DONE: SHALL hold out_valid=1, out_word and out_err stable, with dis_l=1 and select lines at 0.
REQ-022 DONE: when out_valid and out_ready are both 1, SHALL complete the transfer on that edge.
REQ-023 DONE: if start=1 on the transfer edge, SHALL go directly to DRIVE with idx=0 (back-to-back scan); otherwise SHALL go to IDLE.
REQ-024 Latency: out_valid SHALL rise exactly 8*(SETTLE+1) edges after the start-accept edge (16 edges for SETTLE=1).
REQ-025 start SHALL be ignored in DRIVE and SAMPLE, and in DONE except on the transfer edge.
REQ-026 abort=1 in DRIVE or SAMPLE SHALL return to IDLE on the next edge with no out_valid and out_word unchanged.
REQ-027 abort SHALL have no effect in IDLE or DONE.
REQ-028 If abort and a SAMPLE capture occur on the same edge, abort SHALL win and the capture SHALL NOT be recorded.
REQ-029 busy SHALL be 1 exactly in DRIVE and SAMPLE.
REQ-030 idx SHALL be 3 bits and SHALL never wrap: the SAMPLE at idx=7 exits to DONE.
REQ-031 The settle counter SHALL be 4 bits and SHALL reload to SETTLE on each DRIVE entry.
REQ-032 out_err SHALL be the OR of all complement-check failures in the current scan.
REQ-033 out_word and out_err SHALL update only on SAMPLE edges and SHALL be cleared on start accept.

Reset
REQ-034 rstn_pad=0 SHALL immediately force state IDLE, idx=0, the select lines to 0, dis_l=1, busy=0, out_valid=0, out_word=0 and out_err=0, regardless of the current state.
REQ-035 After rstn_pad deasserts, the block SHALL accept no start earlier than the first rising edge.

Verification
REQ-036 SETTLE=1, channels a..h={1,0,1,1,0,0,1,0}, n_in=~m_in, pulse start, out_ready=1 -> select sequence 0..7, each index held 2 cycles, dis_l=0 during the scan; out_word=8'h4D, out_err=0, out_valid for 1 cycle at edge 16.
REQ-037 Same scan with n_in forced equal to m_in at channel 5 only -> out_word=8'h4D, out_err=1.
REQ-038 out_ready=0 for 5 cycles after DONE -> out_valid, out_word and out_err held for all 5 cycles; start pulses during the hold are ignored.
REQ-039 abort asserted at the SAMPLE of idx=3 -> IDLE next edge, no out_valid, capture for idx=3 discarded, dis_l=1.
REQ-040 start held high with out_ready=1 -> continuous back-to-back scans, each out_valid pulse exactly 16 cycles apart (SETTLE=1).
REQ-041 rstn_pad pulsed low asynchronously mid-DRIVE at idx=4 -> all outputs at reset values with no clock edge needed; next start begins again at idx=0.
